nios_system_quad_encoder: RTL and testbench



---
 rtl/nios_system_quad_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_nios_system_quad_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_quad_encoder.sv
// -----------------------------------------------------------------------------
// nios_system_quad_encoder
//
// Quadrature encoder interface for the Nios II system. The raw A/B pins are
// synchronised, glitch-filtered and 4x decoded into a signed position count.
// The count can be read and preset over an Avalon-MM slave. A level clear from
// the encoder-reset PIO forces the count to zero. Illegal (double-bit)
// transitions raise a sticky error flag.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     Avalon-MM word address (0: count, 1: status/control)
//   chipselect  Avalon-MM select
//   write_n     Avalon-MM write strobe, active-low
//   writedata   Avalon-MM write data
//   readdata    Avalon-MM read data, combinational, zero wait states
//   enc_a       raw encoder channel A (asynchronous)
//   enc_b       raw encoder channel B (asynchronous)
//   enc_clear   level count clear, synchronous to clk
// -----------------------------------------------------------------------------
module nios_system_quad_encoder #(
  parameter int COUNT_WIDTH = 32,  // 8..32
  parameter int FILTER_LEN  = 4    // 1..15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_clear
);

  // Filter and sync settle before decoding is allowed.
  localparam int WARM_LEN = FILTER_LEN + 3;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_e;

  // Channel vectors are packed as {A, B}.
  logic [1:0]      sync1, sync2;
  logic [1:0]      filt, prev;
  logic [1:0][3:0] run;
  logic [4:0]      warm_cnt;
  logic            armed;

  logic [COUNT_WIDTH-1:0] count;
  logic                   dir;
  logic                   err;

  step_e      step;
  logic [1:0] pos_prev, pos_cur, pos_diff;
  logic       wr_en, wr_count, wr_err_clr;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for both channels.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its source; blocking assignments here would collapse
  // the two synchroniser stages into one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Warm-up: counts FILTER_LEN+3 edges after reset release, then holds.
  // ---------------------------------------------------------------------------
  assign armed = (warm_cnt == 5'(WARM_LEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
    end else if (!armed) begin
      warm_cnt <= warm_cnt + 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel filter. A channel's run counter climbs on every edge where
  // sync2 disagrees with the filtered level; once it has seen FILTER_LEN such
  // edges the next disagreeing edge accepts the new level. Any agreeing sample
  // restarts the run, so pulses of FILTER_LEN cycles or less are rejected.
  // prev trails filt by one edge for the decoder.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      prev <= '0;
      run  <= '0;
    end else if (!armed) begin
      filt <= sync2;
      prev <= sync2;
      run  <= '0;
    end else begin
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          run[i] <= 4'd0;
        end else if (run[i] == 4'(FILTER_LEN)) begin
          filt[i] <= sync2[i];
          run[i]  <= 4'd0;
        end else begin
          run[i] <= run[i] + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Quadrature decode. Mapping {A,B} to a position index {A, A^B} turns the
  // Gray sequence 00,01,11,10 into 0,1,2,3; the modulo-4 difference then
  // gives +1 forward, 3 reverse, 2 for a double-bit (illegal) change.
  // ---------------------------------------------------------------------------
  assign pos_prev = {prev[1], prev[1] ^ prev[0]};
  assign pos_cur  = {filt[1], filt[1] ^ filt[0]};
  assign pos_diff = pos_cur - pos_prev;

  // NOTE: step is given a default before any branch so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    step = STEP_NONE;
    if (armed) begin
      unique case (pos_diff)
        2'd1:    step = STEP_FWD;
        2'd3:    step = STEP_REV;
        2'd2:    step = STEP_ILLEGAL;
        default: step = STEP_NONE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Avalon-MM write decode.
  // ---------------------------------------------------------------------------
  assign wr_en      = chipselect && !write_n;
  assign wr_count   = wr_en && (address == 2'd0);
  assign wr_err_clr = wr_en && (address == 2'd1) && writedata[1];

  // ---------------------------------------------------------------------------
  // Count: clear beats preset beats decode. dir and err follow the decoder
  // regardless of what happens to the count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enc_clear) begin
      count <= '0;
    end else if (wr_count) begin
      count <= writedata[COUNT_WIDTH-1:0];
    end else if (step == STEP_FWD) begin
      count <= count + COUNT_ONE;
    end else if (step == STEP_REV) begin
      count <= count - COUNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir <= 1'b0;
      err <= 1'b0;
    end else begin
      if (step == STEP_FWD) begin
        dir <= 1'b1;
      end else if (step == STEP_REV) begin
        dir <= 1'b0;
      end
      // A new illegal transition wins over a same-cycle software clear.
      if (step == STEP_ILLEGAL) begin
        err <= 1'b1;
      end else if (wr_err_clr) begin
        err <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux, zero wait states; forced to zero while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    if (reset_n) begin
      unique case (address)
        2'd0:    readdata = 32'($signed(count));
        2'd1:    readdata = {29'b0, enc_clear, err, dir};
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_quad_encoder.sv
// -----------------------------------------------------------------------------
// tb_nios_system_quad_encoder
//
// Self-checking bench for nios_system_quad_encoder. Two instances share all
// inputs: one with the default 32-bit counter, one with an 8-bit counter. A
// behavioural model tracks encoder position, count, dir and err from the
// encoder's Gray-code rules; the 8-bit instance is expected to read the
// sign-extended low byte of the model count.
// -----------------------------------------------------------------------------
module tb_nios_system_quad_encoder;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd32, rd8;
  logic        enc_a, enc_b, enc_clear;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_count;
  logic        m_dir;
  logic        m_err;
  int          m_pos;  // 0..3 along the forward sequence 00,01,11,10

  always #5 clk = ~clk;

  nios_system_quad_encoder #(.COUNT_WIDTH(32), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd32),
    .enc_a(enc_a), .enc_b(enc_b), .enc_clear(enc_clear)
  );

  nios_system_quad_encoder #(.COUNT_WIDTH(8), .FILTER_LEN(FL)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd8),
    .enc_a(enc_a), .enc_b(enc_b), .enc_clear(enc_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] gray(input int pos);
    case (pos & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Move the encoder: +1 forward, -1 reverse, 2 double-bit jump.
  task automatic move(input int delta);
    m_pos = (m_pos + delta) & 3;
    {enc_a, enc_b} = gray(m_pos);
    if (delta == 2) begin
      m_err = 1'b1;
    end else begin
      m_dir = (delta == 1);
      if (!enc_clear) m_count = (delta == 1) ? m_count + 32'd1 : m_count - 32'd1;
    end
  endtask

  task automatic settle(input int extra);
    repeat (FL + 4 + extra) tick();
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
  endtask

  task automatic preset(input logic [31:0] d);
    av_write(2'd0, d);
    m_count = enc_clear ? 32'd0 : d;
  endtask

  task automatic check_count(input string tag, input logic [31:0] exp);
    address = 2'd0; #1;
    check({tag, "_cnt"}, rd32, exp);
    check({tag, "_cnt8"}, rd8, {{24{exp[7]}}, exp[7:0]});
  endtask

  task automatic check_state(input string tag);
    check_count(tag, m_count);
    address = 2'd1; #1;
    check({tag, "_st"}, rd32, {29'b0, enc_clear, m_err, m_dir});
    check({tag, "_st8"}, rd8, {29'b0, enc_clear, m_err, m_dir});
    address = 2'd0;
  endtask

  task automatic glitch(input int ch, input int len);
    if (ch == 0) enc_a = ~enc_a; else enc_b = ~enc_b;
    repeat (len) tick();
    {enc_a, enc_b} = gray(m_pos);
  endtask

  task automatic model_reset();
    m_count = '0; m_dir = 1'b0; m_err = 1'b0;
  endtask

  initial begin
    logic [31:0] prior;
    logic [31:0] d;
    int          r;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; enc_clear = 1'b0;
    m_pos = 2; {enc_a, enc_b} = gray(m_pos);
    model_reset();
    repeat (3) tick();
    address = 2'd1; #1;
    check("in_reset_st", rd32, 32'd0);
    address = 2'd0;

    // Reset release with idle A=B=1
    reset_n = 1'b1;
    repeat (20) tick();
    check_state("reset");

    // Eight forward steps, exact latency of each
    for (int i = 0; i < 8; i++) begin
      prior = m_count;
      move(1);
      repeat (FL + 3) tick();
      check_count($sformatf("lat_pre%0d", i), prior);
      tick();
      check_count($sformatf("lat_post%0d", i), m_count);
      repeat (2) tick();
    end
    check_state("fwd8");

    // Reverse from zero
    preset(32'd0);
    move(-1); settle(0);
    check_state("rev0");

    // Wrap of both widths
    preset(32'h7FFF_FFFF);
    move(1); settle(0);
    check_state("wrap32");
    preset(32'h0000_007F);
    move(1); settle(0);
    check_state("wrap8");

    // Glitches up to FILTER_LEN long are rejected
    glitch(0, 3); settle(0);
    check_state("glitch3");
    glitch(1, FL); settle(0);
    check_state("glitchfl");

    // Illegal transition and software clear of err
    move(2); settle(0);
    check_state("illegal");
    av_write(2'd1, 32'h2); m_err = 1'b0;
    check_state("errclr");

    // enc_clear during forward steps
    enc_clear = 1'b1; m_count = '0;
    tick();
    check_count("clr_first", 32'd0);
    for (int i = 0; i < 3; i++) begin
      move(1); settle(0);
    end
    check_state("clr_steps");
    enc_clear = 1'b0;
    tick();
    move(1); settle(0);
    check_state("clr_resume");

    // Preset on the same edge as a decode step
    move(1);
    repeat (FL + 3) tick();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h0000_1234;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    m_count = 32'h0000_1234;
    check_count("preset_vs_step", m_count);
    settle(0);

    // Preset coincident with enc_clear
    enc_clear = 1'b1;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h0000_0055;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    m_count = '0;
    check_count("preset_vs_clr", 32'd0);
    enc_clear = 1'b0;
    tick();

    // err clear on the same edge as a new illegal transition
    move(2);
    repeat (FL + 3) tick();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h2;
    tick();
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    settle(0);
    check_state("errclr_vs_illegal");
    av_write(2'd1, 32'h2); m_err = 1'b0;

    // Write without chipselect is ignored
    preset(32'h0000_0010);
    write_n = 1'b0; address = 2'd0; writedata = 32'hDEAD_BEEF;
    tick();
    write_n = 1'b1; writedata = '0;
    check_state("no_cs");

    // Unmapped addresses read zero
    address = 2'd2; #1; check("addr2", rd32, 32'd0);
    address = 2'd3; #1; check("addr3", rd32, 32'd0);
    address = 2'd0;

    // Randomised mix of operations against the model
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        move(($urandom_range(0, 1) == 1) ? 1 : -1);
        settle($urandom_range(0, 4));
      end else if (r == 6) begin
        glitch($urandom_range(0, 1), $urandom_range(1, FL));
        settle($urandom_range(0, 4));
      end else if (r == 7) begin
        d = $urandom;
        preset(d);
      end else if (r == 8) begin
        av_write(2'd1, 32'h2); m_err = 1'b0;
      end else begin
        move(2);
        settle($urandom_range(0, 4));
      end
      check_state($sformatf("rnd%0d", i));
    end

    // Reset in mid-operation
    preset(32'h0000_0321);
    move(1); settle(0);
    reset_n = 1'b0; #1;
    address = 2'd0; #1; check("midrst_cnt", rd32, 32'd0);
    address = 2'd1; #1; check("midrst_st", rd32, 32'd0);
    address = 2'd0;
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check_state("after_rst");
    move(-1); settle(0);
    check_state("after_rst_step");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
